// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall bus between the ID-stage pipeline logic and hazard_stall_controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface hazard_stall_controller_if;
   logic [4:0] IF_ID_Rs;
   logic [4:0] IF_ID_Rt;
   logic       ID_usesRt;
   logic       ID_isBranch;
   logic       ID_branchTaken;
   logic       ID_isJump;
   logic       ID_needsMdu;
   logic       ID_EX_MemRead;
   logic       ID_EX_Regwrite;
   logic [4:0] ID_EX_WriteReg;
   logic       EX_isMdu;
   logic       EX_MemMemRead;
   logic [4:0] EX_MemWriteReg;
   logic       PC_write;
   logic       IF_ID_write;
   logic       ID_EX_bubble;
   logic       IF_ID_flush;
   logic       mdu_start;
   logic       mdu_busy;

   modport master (
      output IF_ID_Rs, IF_ID_Rt, ID_usesRt, ID_isBranch, ID_branchTaken, ID_isJump,
             ID_needsMdu, ID_EX_MemRead, ID_EX_Regwrite, ID_EX_WriteReg, EX_isMdu,
             EX_MemMemRead, EX_MemWriteReg,
      input  PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, mdu_start, mdu_busy
   );

   modport slave (
      input  IF_ID_Rs, IF_ID_Rt, ID_usesRt, ID_isBranch, ID_branchTaken, ID_isJump,
             ID_needsMdu, ID_EX_MemRead, ID_EX_Regwrite, ID_EX_WriteReg, EX_isMdu,
             EX_MemMemRead, EX_MemWriteReg,
      output PC_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, mdu_start, mdu_busy
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/bubble/flush sequencer for the 5-stage MIPS core: load-use, branch-in-ID and MDU-busy hazards.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_stall_controller #(
   parameter int MDU_LATENCY = 4,
   parameter int PERF_W      = 16
) (
   input  logic clk,
   input  logic reset,
   hazard_stall_controller_if.slave hz
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {RUN, LD_BR_STALL, MDU_WAIT} state_t;

   localparam logic [3:0] MDU_LAT = 4'(MDU_LATENCY);

   state_t     state, state_next;
   logic [3:0] mdu_cnt;
   logic       mdu_start_int, mdu_busy_int;
   logic       match_ex, match_mem;
   logic       h_mdu, h_lu, h_balu, h_bmem, h_bld;
   logic       stall, flush;

   assign mdu_start_int = hz.EX_isMdu & ~reset;
   assign mdu_busy_int  = (mdu_cnt != 4'd0) | mdu_start_int;

   // Register $0 is never a real destination, so it can never cause a dependency.
   assign match_ex  = (hz.ID_EX_WriteReg != 5'd0) &
                      ((hz.ID_EX_WriteReg == hz.IF_ID_Rs) |
                       (hz.ID_usesRt & (hz.ID_EX_WriteReg == hz.IF_ID_Rt)));
   assign match_mem = (hz.EX_MemWriteReg != 5'd0) &
                      ((hz.EX_MemWriteReg == hz.IF_ID_Rs) |
                       (hz.ID_usesRt & (hz.EX_MemWriteReg == hz.IF_ID_Rt)));

   assign h_mdu  = hz.ID_needsMdu & mdu_busy_int;
   assign h_lu   = hz.ID_EX_MemRead & match_ex;
   assign h_balu = hz.ID_isBranch & hz.ID_EX_Regwrite & ~hz.ID_EX_MemRead & match_ex;
   assign h_bmem = hz.ID_isBranch & hz.EX_MemMemRead & match_mem;
   assign h_bld  = hz.ID_isBranch & h_lu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RUN;
         mdu_cnt <= 4'd0;
      end else begin
         state <= state_next;
         if (mdu_start_int)
            mdu_cnt <= MDU_LAT;
         else if (mdu_cnt != 4'd0)
            mdu_cnt <= mdu_cnt - 4'd1;
      end
   end

   // Reset overrides everything below so the pipeline sees a held, bubbled front end.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      flush      = 1'b0;
      unique case (state)
         RUN: begin
            if (h_mdu) begin
               stall      = 1'b1;
               state_next = MDU_WAIT;
            end else if (h_bld) begin
               stall      = 1'b1;
               state_next = LD_BR_STALL;
            end else if (h_lu | h_balu | h_bmem) begin
               stall = 1'b1;
            end else begin
               flush = (hz.ID_isBranch & hz.ID_branchTaken) | hz.ID_isJump;
            end
         end
         LD_BR_STALL: begin
            stall      = 1'b1;
            state_next = RUN;
         end
         MDU_WAIT: begin
            if (mdu_busy_int)
               stall = 1'b1;
            else
               state_next = RUN;
         end
         default: state_next = RUN;
      endcase
      if (reset) begin
         stall = 1'b1;
         flush = 1'b0;
      end
   end

   assign hz.PC_write     = ~stall;
   assign hz.IF_ID_write  = ~stall;
   assign hz.ID_EX_bubble = stall;
   assign hz.IF_ID_flush  = flush;
   assign hz.mdu_start    = mdu_start_int;
   assign hz.mdu_busy     = mdu_busy_int;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall && (perf_stall_cnt != {PERF_W{1'b1}}))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (flush && (perf_flush_cnt != {PERF_W{1'b1}}))
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`endif

endmodule
